// File: rtl/knn_topk_if.sv
// Candidate stream between the distance core and the top-K list.
// The distance core drives the master side; knn_topk uses the slave side.
interface knn_topk_if #(
   parameter int DIST_W  = 32,
   parameter int LABEL_W = 8
) ();
   logic               in_valid;
   logic               in_ready;
   logic [DIST_W-1:0]  in_dist;
   logic [LABEL_W-1:0] in_label;
   logic               in_last;

   modport master (
      output in_valid, in_dist, in_label, in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_dist, in_label, in_last,
      output in_ready
   );
endinterface

// File: rtl/knn_topk.sv
// Keeps the K nearest candidates of one query, sorted ascending by distance.
// One candidate is accepted per two cycles: capture in IDLE, sorted insert in INSERT.
module knn_topk #(
   parameter  int K       = 4,
   parameter  int DIST_W  = 32,
   parameter  int LABEL_W = 8,
   localparam int IDX_W   = $clog2(K),
   localparam int CNT_W   = $clog2(K + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   knn_topk_if.slave          bus,
   input  logic [IDX_W-1:0]   rd_idx,
   output logic [DIST_W-1:0]  rd_dist,
   output logic [LABEL_W-1:0] rd_label,
   output logic [CNT_W-1:0]   count,
   output logic               done
);

   typedef enum logic [1:0] {IDLE, INSERT, DONE} state_t;

   state_t state_q, state_d;
   logic   ready_c;
   logic   take_c;

   logic [DIST_W-1:0]  cand_dist_q;
   logic [LABEL_W-1:0] cand_label_q;
   logic               cand_last_q;

   logic [DIST_W-1:0]  slot_dist_q  [K];
   logic [DIST_W-1:0]  slot_dist_d  [K];
   logic [LABEL_W-1:0] slot_label_q [K];
   logic [LABEL_W-1:0] slot_label_d [K];
   logic               slot_occ_q   [K];
   logic               slot_occ_d   [K];
   logic [CNT_W-1:0]   count_q, count_d;

   logic               le      [K];
   logic               le_prev [K];
   logic [DIST_W-1:0]  prev_dist  [K];
   logic [LABEL_W-1:0] prev_label [K];
   logic               prev_occ   [K];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == CNT_W'(K)) ? c : c + CNT_W'(1);
   endfunction

   // ---- control FSM ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ready_c = 1'b0;
      take_c  = 1'b0;
      case (state_q)
         IDLE: begin
            ready_c = 1'b1;
            if (bus.in_valid) begin
               take_c  = 1'b1;
               state_d = INSERT;
            end
         end
         INSERT:  state_d = cand_last_q ? DONE : IDLE;
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
      if (clr) state_d = IDLE;
   end

   assign bus.in_ready = ready_c;
   assign done         = (state_q == DONE);

   // ---- candidate capture (data only, no reset needed) ----
   always_ff @(posedge clk) begin
      if (take_c) begin
         cand_dist_q  <= bus.in_dist;
         cand_label_q <= bus.in_label;
         cand_last_q  <= bus.in_last;
      end
   end

   // le is a thermometer code because occupied slots are sorted and contiguous;
   // the first zero after a one marks the insertion position p.
   for (genvar g = 0; g < K; g++) begin : g_cmp
      assign le[g] = slot_occ_q[g] && (slot_dist_q[g] <= cand_dist_q);
      if (g == 0) begin : g_head
         assign le_prev[g]    = 1'b1;
         assign prev_dist[g]  = '1;
         assign prev_label[g] = '0;
         assign prev_occ[g]   = 1'b0;
      end else begin : g_body
         assign le_prev[g]    = le[g-1];
         assign prev_dist[g]  = slot_dist_q[g-1];
         assign prev_label[g] = slot_label_q[g-1];
         assign prev_occ[g]   = slot_occ_q[g-1];
      end
   end

   // ---- sorted insert ----
   always_comb begin
      for (int i = 0; i < K; i++) begin
         slot_dist_d[i]  = slot_dist_q[i];
         slot_label_d[i] = slot_label_q[i];
         slot_occ_d[i]   = slot_occ_q[i];
      end
      count_d = count_q;
      if (clr) begin
         for (int i = 0; i < K; i++) begin
            slot_dist_d[i]  = '1;
            slot_label_d[i] = '0;
            slot_occ_d[i]   = 1'b0;
         end
         count_d = '0;
      end else if (state_q == INSERT && !le[K-1]) begin
         for (int i = 0; i < K; i++) begin
            if (!le[i]) begin
               if (le_prev[i]) begin
                  slot_dist_d[i]  = cand_dist_q;
                  slot_label_d[i] = cand_label_q;
                  slot_occ_d[i]   = 1'b1;
               end else begin
                  slot_dist_d[i]  = prev_dist[i];
                  slot_label_d[i] = prev_label[i];
                  slot_occ_d[i]   = prev_occ[i];
               end
            end
         end
         count_d = sat_inc(count_q);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < K; i++) begin
            slot_dist_q[i]  <= '1;
            slot_label_q[i] <= '0;
            slot_occ_q[i]   <= 1'b0;
         end
         count_q <= '0;
      end else begin
         for (int i = 0; i < K; i++) begin
            slot_dist_q[i]  <= slot_dist_d[i];
            slot_label_q[i] <= slot_label_d[i];
            slot_occ_q[i]   <= slot_occ_d[i];
         end
         count_q <= count_d;
      end
   end

   assign count = count_q;

   // ---- read port ----
   always_comb begin
      rd_dist  = '1;
      rd_label = '0;
      if (int'(rd_idx) < K) begin
         rd_dist  = slot_dist_q[rd_idx];
         rd_label = slot_label_q[rd_idx];
      end
   end

endmodule

// File: tb/tb_knn_topk.sv
// Directed bench for knn_topk (K=4): table of insertion vectors plus
// hand-written handshake, clear-collision and asynchronous-reset sequences.
module tb_knn_topk;

   localparam logic [31:0] F = 32'hFFFF_FFFF;

   logic        clk;
   logic        rst;
   logic        clr;
   logic [1:0]  rd_idx;
   logic [31:0] rd_dist;
   logic [7:0]  rd_label;
   logic [2:0]  count;
   logic        done;

   int checks = 0;
   int errors = 0;

   knn_topk_if #(.DIST_W(32), .LABEL_W(8)) bus ();

   knn_topk #(.K(4), .DIST_W(32), .LABEL_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .bus      (bus),
      .rd_idx   (rd_idx),
      .rd_dist  (rd_dist),
      .rd_label (rd_label),
      .count    (count),
      .done     (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit          clr_first;
      logic [31:0] d;
      logic [7:0]  l;
      bit          last;
      int          exp_cnt;
      bit          exp_done;
      logic [31:0] ed [4];
      logic [7:0]  el [4];
   } vec_t;

   vec_t vecs [18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit c, input logic [31:0] d, input logic [7:0] l,
                               input bit last, input int cnt, input bit dn,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3,
                               input logic [7:0] l0, input logic [7:0] l1,
                               input logic [7:0] l2, input logic [7:0] l3);
      vec_t r;
      r.clr_first = c;  r.d = d;  r.l = l;  r.last = last;
      r.exp_cnt = cnt;  r.exp_done = dn;
      r.ed[0] = d0; r.ed[1] = d1; r.ed[2] = d2; r.ed[3] = d3;
      r.el[0] = l0; r.el[1] = l1; r.el[2] = l2; r.el[3] = l3;
      return r;
   endfunction

   task automatic do_clr();
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
   endtask

   // Waits (bounded) for in_ready, presents one candidate for exactly one edge.
   task automatic push(input logic [31:0] d, input logic [7:0] l, input bit last);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL push_timeout: in_ready stayed 0, required 1");
      end
      bus.in_valid = 1'b1;
      bus.in_dist  = d;
      bus.in_label = l;
      bus.in_last  = last;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic chk_slot(input string tag, input int s, input logic [31:0] ed, input logic [7:0] el);
      rd_idx = 2'(s);
      #1;
      chk($sformatf("%s slot%0d dist", tag, s), rd_dist, ed);
      chk($sformatf("%s slot%0d label", tag, s), {24'd0, rd_label}, {24'd0, el});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(1, 50, 1, 0, 1, 0, 50, F, F, F, 1, 0, 0, 0);
      vecs[1]  = mk(0, 10, 2, 0, 2, 0, 10, 50, F, F, 2, 1, 0, 0);
      vecs[2]  = mk(0, 30, 3, 0, 3, 0, 10, 30, 50, F, 2, 3, 1, 0);
      vecs[3]  = mk(0, 20, 4, 0, 4, 0, 10, 20, 30, 50, 2, 4, 3, 1);
      vecs[4]  = mk(0, 40, 5, 1, 4, 1, 10, 20, 30, 40, 2, 4, 3, 5);
      vecs[5]  = mk(1, 7, 8'hA, 0, 1, 0, 7, F, F, F, 8'hA, 0, 0, 0);
      vecs[6]  = mk(0, 7, 8'hB, 0, 2, 0, 7, 7, F, F, 8'hA, 8'hB, 0, 0);
      vecs[7]  = mk(0, 7, 8'hC, 0, 3, 0, 7, 7, 7, F, 8'hA, 8'hB, 8'hC, 0);
      vecs[8]  = mk(0, 7, 8'hD, 0, 4, 0, 7, 7, 7, 7, 8'hA, 8'hB, 8'hC, 8'hD);
      vecs[9]  = mk(0, 7, 8'hE, 1, 4, 1, 7, 7, 7, 7, 8'hA, 8'hB, 8'hC, 8'hD);
      vecs[10] = mk(1, 32'h8000_0000, 1, 0, 1, 0, 32'h8000_0000, F, F, F, 1, 0, 0, 0);
      vecs[11] = mk(0, 32'h7FFF_FFFF, 2, 0, 2, 0, 32'h7FFF_FFFF, 32'h8000_0000, F, F, 2, 1, 0, 0);
      vecs[12] = mk(0, F, 3, 1, 3, 1, 32'h7FFF_FFFF, 32'h8000_0000, F, F, 2, 1, 3, 0);
      vecs[13] = mk(1, 40, 1, 0, 1, 0, 40, F, F, F, 1, 0, 0, 0);
      vecs[14] = mk(0, 30, 2, 0, 2, 0, 30, 40, F, F, 2, 1, 0, 0);
      vecs[15] = mk(0, 20, 3, 0, 3, 0, 20, 30, 40, F, 3, 2, 1, 0);
      vecs[16] = mk(0, 10, 4, 0, 4, 0, 10, 20, 30, 40, 4, 3, 2, 1);
      vecs[17] = mk(0, 5, 5, 1, 4, 1, 5, 10, 20, 30, 5, 4, 3, 2);

      rst = 1'b1;
      clr = 1'b0;
      rd_idx = 2'd0;
      bus.in_valid = 1'b0;
      bus.in_dist  = '0;
      bus.in_label = '0;
      bus.in_last  = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst count", {29'd0, count}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      for (int s = 0; s < 4; s++) chk_slot("rst", s, F, 8'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Table-driven insertion vectors
      for (int i = 0; i < 18; i++) begin
         if (vecs[i].clr_first) do_clr();
         push(vecs[i].d, vecs[i].l, vecs[i].last);
         repeat (2) @(negedge clk);
         chk($sformatf("row%0d count", i), {29'd0, count}, 32'(vecs[i].exp_cnt));
         chk($sformatf("row%0d done", i), {31'd0, done}, {31'd0, vecs[i].exp_done});
         chk($sformatf("row%0d in_ready", i), {31'd0, bus.in_ready}, {31'd0, !vecs[i].exp_done});
         for (int s = 0; s < 4; s++)
            chk_slot($sformatf("row%0d", i), s, vecs[i].ed[s], vecs[i].el[s]);
      end

      // DONE ignores in_valid; clr in DONE with a pending dist 5 empties the list
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_dist  = 32'd1;
      bus.in_label = 8'd9;
      bus.in_last  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("done frozen count", {29'd0, count}, 32'd4);
      chk("done frozen done", {31'd0, done}, 32'd1);
      chk_slot("done frozen", 0, 32'd5, 8'd5);
      @(negedge clk);
      clr = 1'b1;
      bus.in_dist = 32'd5;
      @(posedge clk);
      #1;
      clr = 1'b0;
      bus.in_valid = 1'b0;
      chk("clr done count", {29'd0, count}, 32'd0);
      chk("clr done done", {31'd0, done}, 32'd0);
      chk("clr done in_ready", {31'd0, bus.in_ready}, 32'd1);
      repeat (2) @(negedge clk);
      chk_slot("clr done", 0, F, 8'd0);

      // clr colliding with a genuine transfer in IDLE: transfer is lost
      @(negedge clk);
      clr = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_dist  = 32'd5;
      bus.in_label = 8'd6;
      bus.in_last  = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
      bus.in_valid = 1'b0;
      chk("clr idle in_ready", {31'd0, bus.in_ready}, 32'd1);
      repeat (2) @(negedge clk);
      chk("clr idle count", {29'd0, count}, 32'd0);
      chk("clr idle done", {31'd0, done}, 32'd0);
      chk_slot("clr idle", 0, F, 8'd0);

      // Continuous in_valid: one capture per two cycles
      do_clr();
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_dist  = 32'd100;
      bus.in_label = 8'd0;
      bus.in_last  = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("hs in_ready c%0d", c), {31'd0, bus.in_ready}, {31'd0, (c % 2) == 0});
         @(posedge clk);
         #1;
         bus.in_dist  = 32'(100 + c + 1);
         bus.in_label = 8'(c + 1);
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("hs count", {29'd0, count}, 32'd2);
      chk_slot("hs", 0, 32'd100, 8'd0);
      chk_slot("hs", 1, 32'd102, 8'd2);
      chk_slot("hs", 2, F, 8'd0);

      // Asynchronous reset in the middle of INSERT
      do_clr();
      push(32'd3, 8'd1, 1'b0);
      repeat (2) @(negedge clk);
      push(32'd9, 8'd2, 1'b0);
      rd_idx = 2'd0;
      #1 rst = 1'b1;
      #1;
      chk("arst in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("arst count", {29'd0, count}, 32'd0);
      chk("arst done", {31'd0, done}, 32'd0);
      chk("arst slot0 dist", rd_dist, F);
      chk_slot("arst", 1, F, 8'd0);
      rst = 1'b0;
      push(32'd4, 8'd7, 1'b1);
      chk("post-rst first capture", {31'd0, bus.in_ready}, 32'd0);
      repeat (2) @(negedge clk);
      chk("post-rst count", {29'd0, count}, 32'd1);
      chk("post-rst done", {31'd0, done}, 32'd1);
      chk_slot("post-rst", 0, 32'd4, 8'd7);
      chk_slot("post-rst", 1, F, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/knn_topk.md
KNN_TOPK -- requirements
Module: knn_topk

Interface
REQ-001 Parameter K, 4, number of nearest neighbours kept; SHALL be at least 2.
REQ-002 Parameter DIST_W, 32, distance width (unsigned).
REQ-003 Parameter LABEL_W, 8, class label width.
REQ-004 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 clr  in  1  synchronous clear of list and state.
REQ-007 in_valid  in  1  candidate present.
REQ-008 in_ready  out  1  block can accept a candidate.
REQ-009 in_dist  in  DIST_W  candidate distance, produced by the upstream distance core.
REQ-010 in_label  in  LABEL_W  candidate's class label.
REQ-011 in_last  in  1  candidate is the final training point of the query.
REQ-012 rd_idx  in  clog2(K)  list slot select; slot 0 is the nearest.
REQ-013 rd_dist  out  DIST_W  distance in slot rd_idx, combinational read.
REQ-014 rd_label  out  LABEL_W  label in slot rd_idx, combinational read.
REQ-015 count  out  clog2(K+1)  number of occupied slots, saturating at K.
REQ-016 done  out  1  query complete; list is final.

Function
REQ-017 The block SHALL keep K slots (dist, label, occupied), sorted ascending by dist, with occupied slots contiguous from slot 0.
REQ-018 The FSM SHALL have three states: IDLE, INSERT, DONE.
REQ-019 in_ready SHALL be 1 in IDLE and 0 in INSERT and DONE.
REQ-020 A transfer SHALL occur when in_valid and in_ready are both 1; this captures in_dist, in_label and in_last and moves IDLE->INSERT.
REQ-021 In INSERT, in a single cycle, the block SHALL find position p = the number of occupied slots with dist <= candidate.
REQ-022 It SHALL shift slots p..K-2 down by one, write the candidate into slot p, and drop the old slot K-1.
REQ-023 Ties SHALL be stable: a candidate equal to an existing entry is placed after it.
REQ-024 If p == K (list full, candidate >= slot K-1), the candidate SHALL be discarded and the list left unchanged.
REQ-025 count SHALL increment by one per insertion while below K, and SHALL NOT change on a discard.
REQ-026 INSERT SHALL last exactly one cycle; it moves to DONE if the captured in_last was 1, otherwise to IDLE.
REQ-027 Sustained throughput SHALL therefore be one candidate per 2 cycles.
REQ-028 In DONE, done SHALL be 1, the list SHALL be frozen, and in_valid SHALL be ignored until clr.
REQ-029 clr SHALL have priority over every other event, including a simultaneous transfer, which is then lost.
REQ-030 clr SHALL return the block to IDLE, empty all slots, set count=0 and done=0 on the next edge, whatever the current state.
REQ-031 A candidate transferred with in_last=1 while the list is full and the candidate is discarded SHALL still lead to DONE.
REQ-032 Unoccupied slots SHALL read rd_dist = all-ones and rd_label = 0.
REQ-033 Distance comparisons SHALL be unsigned at full DIST_W.

Reset
REQ-034 While rst is high, the block SHALL hold: state IDLE; all slots unoccupied with dist = all-ones and label = 0; count = 0; done = 0; in_ready = 1.
REQ-035 Reset asserted mid-INSERT SHALL abort the insertion with no partial list update visible after release.
REQ-036 The first transfer SHALL be possible on the first rising edge after rst deasserts.

Verification (K=4, DIST_W=32, LABEL_W=8)
REQ-037 Reset check: after reset, in_ready=1, count=0, done=0, and rd_dist=0xFFFFFFFF with rd_label=0 for every rd_idx.
REQ-038 Ordering: dists 50,10,30,20,40 with labels 1..5, last on the fifth -> slots read (10,2),(20,4),(30,3),(40,5); count=4; done=1.
REQ-039 Ties and discard: 7(a), 7(b), 7(c), 7(d), then 7(e) with last -> slots a,b,c,d; candidate e discarded; done=1.
REQ-040 Handshake: in_valid held high continuously -> in_ready toggles 1,0,1,0; exactly one capture per 2 cycles; no duplicates.
REQ-041 Clear collision: clr together with a transfer of dist 5 in DONE -> next cycle count=0, done=0, state IDLE, and dist 5 absent from the list.
REQ-042 Async reset: rst pulsed between clock edges during INSERT -> outputs take their reset values immediately, without waiting for a clock edge.
